// File: rtl/reg_pipe.sv
// reg_pipe: parametrised valid/ready register pipeline. It has a programmable reset value,
// bubble collapse under backpressure, a synchronous flush and a registered occupancy count.
module reg_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [DEPTH-1:0] rdy_s;
  logic             tail_full_s;
  logic             in_hs_s;
  logic             out_hs_s;

  // Stage ready: a stage can take a word unless it and every stage after it are full and the sink stalls.
  always_comb begin
    tail_full_s = 1'b1;
    rdy_s       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full_s = tail_full_s & v_q[i];
      rdy_s[i]    = out_ready | ~tail_full_s;
    end
  end

  assign in_ready = rdy_s[0] & ~flush;
  assign in_hs_s  = in_valid & in_ready;
  assign out_hs_s = v_q[DEPTH-1] & out_ready;

  // Next-state for stage valids and data; data only moves with a valid word.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (rdy_s[0]) begin
        v_d[0] = in_valid;
        if (in_valid) begin
          d_d[0] = in_data;
        end else begin
          d_d[0] = d_q[0];
        end
      end else begin
        v_d[0] = v_q[0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy_s[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            d_d[i] = d_q[i-1];
          end else begin
            d_d[i] = d_q[i];
          end
        end else begin
          v_d[i] = v_q[i];
        end
      end
    end
  end

  // Next-state for the occupancy counter from the two handshakes.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      case ({in_hs_s, out_hs_s})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers; reset discards every word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= RESET_VAL;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      d_q   <= d_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench for reg_pipe: a DEPTH=3/8-bit instance with an order scoreboard,
// plus a DEPTH=1/32-bit instance for the single-stage edge case.
module tb_reg_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  occupancy;

  logic        b_flush;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [31:0] b_in_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [31:0] b_out_data;
  logic [0:0]  b_occupancy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          model_occ = 0;
  logic [7:0]  exp_q [$];
  logic        dacc;
  logic        demit;

  always #5 clk = ~clk;

  reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  reg_pipe #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'hDEAD_BEEF)) u_dut_d1 (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One cycle on the 3-stage pipe: drive, score the handshakes, clock, check occupancy.
  task automatic drive(input logic iv, input logic [7:0] din, input logic ordy,
                       output logic acc_o, output logic emit_o);
    in_valid  = iv;
    in_data   = din;
    out_ready = ordy;
    #1;
    acc_o  = iv & in_ready;
    emit_o = out_valid & ordy;
    if (emit_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        check("order", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    if (acc_o) exp_q.push_back(din);
    model_occ = model_occ + (acc_o ? 1 : 0) - (emit_o ? 1 : 0);
    @(posedge clk);
    #1;
    check("occ_model", 32'(occupancy), 32'(model_occ));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 32'h0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'hA5);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_d1_data", b_out_data, 32'hDEAD_BEEF);
    flush = 1'b1;
    #1;
    check("rst_in_ready_flush", 32'(in_ready), 32'd0);
    flush = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Two words held, then reset asserted between edges
    drive(1'b1, 8'h5A, 1'b0, dacc, demit);
    drive(1'b1, 8'h6B, 1'b0, dacc, demit);
    drive(1'b0, 8'h00, 1'b0, dacc, demit);
    check("mid_out_valid", 32'(out_valid), 32'd1);
    check("mid_out_data", 32'(out_data), 32'h5A);
    #2 reset = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_data", 32'(out_data), 32'hA5);
    check("async_occ", 32'(occupancy), 32'd0);
    exp_q.delete();
    model_occ = 0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming 0x01..0x10 with out_ready=1
    for (int k = 0; k < 16; k++) begin
      check("stream_vld", 32'(out_valid), 32'(k >= 3));
      if (k >= 3) check("stream_data", 32'(out_data), 32'(k - 2));
      drive(1'b1, 8'(k + 1), 1'b1, dacc, demit);
      check("stream_acc", 32'(dacc), 32'd1);
      check("stream_occ", 32'(occupancy), 32'((k + 1 < 3) ? k + 1 : 3));
    end
    for (int k = 16; k < 19; k++) begin
      check("drain_vld", 32'(out_valid), 32'd1);
      check("drain_data", 32'(out_data), 32'(k - 2));
      drive(1'b0, 8'h00, 1'b1, dacc, demit);
    end
    check("drain_empty", 32'(out_valid), 32'd0);

    // Backpressure and bubble collapse
    drive(1'b1, 8'h11, 1'b0, dacc, demit);
    drive(1'b1, 8'h22, 1'b0, dacc, demit);
    drive(1'b1, 8'h33, 1'b0, dacc, demit);
    check("bp_acc33", 32'(dacc), 32'd1);
    in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b0;
    #1;
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_full_occ", 32'(occupancy), 32'd3);
    check("bp_head", 32'(out_data), 32'h11);
    drive(1'b1, 8'h44, 1'b1, dacc, demit);
    check("bp_acc44", 32'(dacc), 32'd1);
    check("bp_occ_same", 32'(occupancy), 32'd3);
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) drive(1'b0, 8'h00, 1'b1, dacc, demit);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Bubbles with toggling out_ready
    for (int k = 0; k < 5; k++) begin
      drive(((k % 2) == 0), 8'(8'h61 + k), ((k % 2) == 1), dacc, demit);
    end
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) drive(1'b0, 8'h00, 1'b1, dacc, demit);
    check("bub_drained", 32'(exp_q.size()), 32'd0);
    check("bub_occ", 32'(occupancy), 32'd0);

    // Flush a full pipe while 0xDD is offered
    drive(1'b1, 8'hAA, 1'b0, dacc, demit);
    drive(1'b1, 8'hBB, 1'b0, dacc, demit);
    drive(1'b1, 8'hCC, 1'b0, dacc, demit);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hDD; out_ready = 1'b0;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    model_occ = 0;
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_data_kept", 32'(out_data), 32'hAA);
    for (int t = 0; t < 4; t++) drive(1'b0, 8'h00, 1'b1, dacc, demit);
    drive(1'b1, 8'hEE, 1'b1, dacc, demit);
    for (int t = 0; t < 6 && exp_q.size() > 0; t++) drive(1'b0, 8'h00, 1'b1, dacc, demit);
    check("flush_ee_out", 32'(exp_q.size()), 32'd0);

    // Single-stage, 32-bit instance
    b_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_in_valid = 1'b1;
      b_in_data  = 32'h1000_0000 + 32'(k);
      #1;
      check("d1_in_ready", 32'(b_in_ready), 32'd1);
      check("d1_out_valid", 32'(b_out_valid), 32'(k >= 1));
      check("d1_occ", 32'(b_occupancy), 32'(k >= 1));
      if (k >= 1) check("d1_out_data", b_out_data, 32'h1000_0000 + 32'(k - 1));
      @(posedge clk);
      #1;
    end
    b_out_ready = 1'b0;
    #1;
    check("d1_full_stall", 32'(b_in_ready), 32'd0);
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("d1_empty_vld", 32'(b_out_valid), 32'd0);
    check("d1_empty_occ", 32'(b_occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
